sram_rw_port_ctrl: RTL

Front-end controller for a single-port, 1-cycle-read-latency, bit-masked SRAM macro (128 sets × 152 bits default, `RW0_*` port). It sits directly upstream of the macro and owns its only port. After reset it zero-fills the array, then arbitrates independent read and write request channels onto the port. Read data is captured into a 2-entry response FIFO with valid/ready back-pressure, so consumers may stall without losing data.

---
 rtl/sram_rw_port_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sram_rw_port_ctrl.sv
// sram_rw_port_ctrl
// Front-end controller that owns the single RW0 port of a 1-cycle-latency,
// bit-masked SRAM macro. After reset it zero-fills the array, then arbitrates
// independent read and write request channels onto the port. Read data lands
// in a 2-entry response FIFO so consumers can stall without losing data.
//
// Ports
//   clock, reset            : sole clock, synchronous active-high reset
//   io_r_req_*              : read request channel (valid/ready, setIdx)
//   io_r_resp_*             : read response channel (valid/ready, data)
//   io_w_req_*              : write request channel (valid/ready, setIdx, data, mask)
//   io_init_done            : high once the zero-fill has finished
//   RW0_addr/en/wmode/wmask/wdata : macro command, driven combinationally
//   RW0_rdata               : macro read data, valid the cycle after a read
module sram_rw_port_ctrl #(
  parameter int unsigned SETS          = 128,
  parameter int unsigned ADDR_W        = 7,
  parameter int unsigned WIDTH         = 152,
  parameter bit          INIT_ON_RESET = 1'b1,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_r_req_valid,
  output logic              io_r_req_ready,
  input  logic [ADDR_W-1:0] io_r_req_bits_setIdx,
  output logic              io_r_resp_valid,
  input  logic              io_r_resp_ready,
  output logic [WIDTH-1:0]  io_r_resp_bits_data,
  input  logic              io_w_req_valid,
  output logic              io_w_req_ready,
  input  logic [ADDR_W-1:0] io_w_req_bits_setIdx,
  input  logic [WIDTH-1:0]  io_w_req_bits_data,
  input  logic [WIDTH-1:0]  io_w_req_bits_mask,
  output logic              io_init_done,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [WIDTH-1:0]  RW0_wmask,
  output logic [WIDTH-1:0]  RW0_wdata,
  input  logic [WIDTH-1:0]  RW0_rdata
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  // Low only in the first cycle after reset, so that cycle leaves the port idle
  logic              init_armed;
  logic [ADDR_W-1:0] init_cnt;
  logic              inflight;
  logic [SW-1:0]     starve_cnt;
  logic [1:0]        fifo_count;
  logic [WIDTH-1:0]  fifo_head;
  logic [WIDTH-1:0]  fifo_tail;

  logic              resp_pop;
  logic [1:0]        credit;
  logic              read_eligible;
  logic              starve_hit;
  logic              read_wins;
  logic              r_fire;
  logic              w_fire;

  // Credit counts queued responses plus the read whose data arrives next
  // cycle; a pop happening this cycle frees its slot in time for a new read.
  assign resp_pop      = (fifo_count != 2'd0) & io_r_resp_ready;
  assign credit        = fifo_count + {1'b0, inflight};
  assign read_eligible = (credit - {1'b0, resp_pop}) < 2'd2;
  assign starve_hit    = (starve_cnt == SW'(STARVE_LIMIT));
  // Writes win unless the read has been starved long enough; an ineligible
  // read never takes the port, so the write is not stalled for nothing.
  assign read_wins     = io_r_req_valid & read_eligible & (starve_hit | ~io_w_req_valid);

  assign io_init_done        = (state == RUN);
  assign io_r_resp_valid     = (fifo_count != 2'd0);
  assign io_r_resp_bits_data = fifo_head;

  // Next-state, request readies and the macro command
  always_comb begin
    state_next     = state;
    io_r_req_ready = 1'b0;
    io_w_req_ready = 1'b0;
    r_fire         = 1'b0;
    w_fire         = 1'b0;
    RW0_en         = 1'b0;
    RW0_wmode      = 1'b0;
    RW0_addr       = '0;
    RW0_wmask      = '0;
    RW0_wdata      = '0;
    case (state)
      INIT: begin
        if (INIT_ON_RESET) begin
          if (init_armed) begin
            RW0_en    = 1'b1;
            RW0_wmode = 1'b1;
            RW0_addr  = init_cnt;
            RW0_wmask = '1;
            if (init_cnt == ADDR_W'(SETS - 1)) begin
              state_next = RUN;
            end
          end
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        io_r_req_ready = read_wins;
        io_w_req_ready = ~read_wins;
        r_fire         = read_wins;
        w_fire         = io_w_req_valid & ~read_wins;
        if (w_fire) begin
          RW0_en    = 1'b1;
          RW0_wmode = 1'b1;
          RW0_addr  = io_w_req_bits_setIdx;
          RW0_wmask = io_w_req_bits_mask;
          RW0_wdata = io_w_req_bits_data;
        end else if (r_fire) begin
          RW0_en   = 1'b1;
          RW0_addr = io_r_req_bits_setIdx;
        end
      end
      default: state_next = INIT;
    endcase
  end

  // Control state: FSM, init counter, in-flight flag, starvation counter and
  // FIFO occupancy. The in-flight read is pushed the cycle after it issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= INIT;
      init_armed <= 1'b0;
      init_cnt   <= '0;
      inflight   <= 1'b0;
      starve_cnt <= '0;
      fifo_count <= 2'd0;
    end else begin
      state      <= state_next;
      init_armed <= 1'b1;
      inflight   <= r_fire;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, resp_pop};
      if (state == INIT && init_armed) begin
        init_cnt <= init_cnt + ADDR_W'(1);
      end
      if (state == RUN) begin
        if (r_fire || !io_r_req_valid) begin
          starve_cnt <= '0;
        end else if (read_eligible && w_fire) begin
          starve_cnt <= starve_cnt + SW'(1);
        end
      end
    end
  end

  // FIFO storage: the head is always the oldest entry, so a pop shifts the
  // tail forward and a push lands in whichever slot is next free.
  always_ff @(posedge clock) begin
    case ({inflight, resp_pop})
      2'b01: fifo_head <= fifo_tail;
      2'b10: begin
        if (fifo_count == 2'd0) begin
          fifo_head <= RW0_rdata;
        end else begin
          fifo_tail <= RW0_rdata;
        end
      end
      2'b11: begin
        if (fifo_count == 2'd2) begin
          fifo_head <= fifo_tail;
          fifo_tail <= RW0_rdata;
        end else begin
          fifo_head <= RW0_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule
